// File: rtl/imm_encoder.sv
// imm_encoder: scatters a signed immediate into a RISC-V
// instruction template through a 2-stage valid/ready pipe.
module imm_encoder #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_inst,
  input  logic [31:0]        in_imm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_inst,
  output logic [1:0]         out_err,
  output logic [COUNT_W-1:0] err_count
);

  typedef enum logic [2:0] {
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_X
  } fmt_e;

  logic               s1_valid_q, s1_valid_d;
  logic [31:0]        s1_inst_q, s1_inst_d;
  logic [31:0]        s1_imm_q, s1_imm_d;
  fmt_e               s1_fmt_q, s1_fmt_d;
  logic [1:0]         s1_err_q, s1_err_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_inst_q, out_inst_d;
  logic [1:0]         out_err_q, out_err_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  logic        s2_free;
  logic        accept;
  fmt_e        fmt;
  logic [1:0]  chk;
  logic        rng12, rng13, rng21;
  logic [31:0] merged;

  assign s2_free  = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_free;
  assign accept   = in_valid && in_ready;

  // imm fits when every bit above the field's sign bit matches it
  assign rng12 = (&in_imm[31:11]) || !(|in_imm[31:11]);
  assign rng13 = (&in_imm[31:12]) || !(|in_imm[31:12]);
  assign rng21 = (&in_imm[31:20]) || !(|in_imm[31:20]);

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_err   = out_err_q;
  assign err_count = cnt_q;

  // Classify the template's opcode into an immediate format
  always_comb begin
    fmt = FMT_X;
    unique case (in_inst[6:0])
      7'b0000011,
      7'b0010011,
      7'b1100111: fmt = FMT_I;
      7'b0100011: fmt = FMT_S;
      7'b1100011: fmt = FMT_B;
      7'b0110111: fmt = FMT_U;
      7'b1101111: fmt = FMT_J;
      default:    fmt = FMT_X;
    endcase
  end

  // Opcode, then alignment, then range, highest priority first
  always_comb begin
    chk = 2'd0;
    unique case (fmt)
      FMT_X: chk = 2'd3;
      FMT_I,
      FMT_S: if (!rng12) chk = 2'd1;
      FMT_B: begin
        if (in_imm[0])   chk = 2'd2;
        else if (!rng13) chk = 2'd1;
      end
      FMT_U: if (in_imm[11:0] != 12'd0) chk = 2'd2;
      FMT_J: begin
        if (in_imm[0])   chk = 2'd2;
        else if (!rng21) chk = 2'd1;
      end
      default: chk = 2'd3;
    endcase
  end

  // S1 loads on accept and empties when S2 takes its item
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_inst_d  = s1_inst_q;
    s1_imm_d   = s1_imm_q;
    s1_fmt_d   = s1_fmt_q;
    s1_err_d   = s1_err_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_inst_d  = in_inst;
      s1_imm_d   = in_imm;
      s1_fmt_d   = fmt;
      s1_err_d   = chk;
    end else if (s2_free) begin
      s1_valid_d = 1'b0;
    end
  end

  // Scatter the held immediate over the format's bit fields
  always_comb begin
    merged = s1_inst_q;
    unique case (s1_fmt_q)
      FMT_I: merged = {s1_imm_q[11:0], s1_inst_q[19:0]};
      FMT_S: merged = {s1_imm_q[11:5], s1_inst_q[24:12],
                       s1_imm_q[4:0], s1_inst_q[6:0]};
      FMT_B: merged = {s1_imm_q[12], s1_imm_q[10:5],
                       s1_inst_q[24:12], s1_imm_q[4:1],
                       s1_imm_q[11], s1_inst_q[6:0]};
      FMT_U: merged = {s1_imm_q[31:12], s1_inst_q[11:0]};
      FMT_J: merged = {s1_imm_q[20], s1_imm_q[10:1],
                       s1_imm_q[11], s1_imm_q[19:12],
                       s1_inst_q[11:0]};
      default: merged = s1_inst_q;
    endcase
  end

  // S2 holds while stalled, otherwise takes whatever S1 has
  always_comb begin
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_err_d   = out_err_q;
    if (s2_free) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_inst_d = merged;
        out_err_d  = s1_err_q;
      end
    end
  end

  // Count errored results as they leave, saturating at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid_q && out_ready && out_err_q != 2'd0
        && cnt_q != '1)
      cnt_d = cnt_q + COUNT_W'(1);
  end

  // Pipeline and counter registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_inst_q   <= 32'd0;
      s1_imm_q    <= 32'd0;
      s1_fmt_q    <= FMT_X;
      s1_err_q    <= 2'd0;
      out_valid_q <= 1'b0;
      out_inst_q  <= 32'd0;
      out_err_q   <= 2'd0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_inst_q   <= s1_inst_d;
      s1_imm_q    <= s1_imm_d;
      s1_fmt_q    <= s1_fmt_d;
      s1_err_q    <= s1_err_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_err_q   <= out_err_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule
